// File: rtl/multi_channel_dual_slope_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : multi_channel_dual_slope_pwm
//  Description : Multi-channel centre-aligned (dual-slope) PWM generator.
//                A single up/down counter is shared by all channels. Period
//                (TOP) and per-channel duty values are double-buffered and
//                take effect only at the period valley, so outputs never
//                glitch. Valley/peak sync pulses are aligned with pwm_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_dual_slope_pwm #(
    parameter int RESOLUTION = 10,
    parameter int CHANNELS   = 4,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [RESOLUTION-1:0] top_in,
    input  logic                  duty_wr_en,
    input  logic [CH_W-1:0]       duty_wr_ch,
    input  logic [RESOLUTION:0]   duty_wr_data,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  sync_valley,
    output logic                  sync_peak
);

    // Counter constants: the largest TOP and the value 1 (used both as the
    // counting step and as the floor for a requested TOP of 0).
    localparam logic [RESOLUTION-1:0] C_TOP_MAX = {RESOLUTION{1'b1}};
    localparam logic [RESOLUTION-1:0] C_ONE     = {{(RESOLUTION-1){1'b0}}, 1'b1};

    // Counting direction is a two-state machine: up from the valley, down
    // from the peak.
    typedef enum logic [0:0] {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    dir_t                  dir_q;
    dir_t                  dir_d;
    logic [RESOLUTION-1:0] cnt_q;
    logic [RESOLUTION-1:0] cnt_d;
    logic [RESOLUTION-1:0] top_act_q;
    logic [RESOLUTION-1:0] top_act_d;
    logic                  sync_valley_q;
    logic                  sync_valley_d;
    logic                  sync_peak_q;
    logic                  sync_peak_d;

    logic                  at_valley;
    logic                  at_peak;
    logic                  load_en;
    logic [RESOLUTION-1:0] top_clamped;

    // Period-boundary detection and the shadow-to-active load condition.
    // While halted the active registers track the shadows every cycle, so a
    // restart uses the newest values from its very first compare.
    always_comb begin
        at_valley   = (cnt_q == '0);
        at_peak     = (cnt_q == top_act_q);
        load_en     = at_valley || !en;
        top_clamped = (top_in == '0) ? C_ONE : top_in;
    end

    // Direction next-state and counter update; halting parks the counter at
    // the valley pointing up so restart resumes 0 -> 1.
    always_comb begin
        dir_d = dir_q;
        cnt_d = cnt_q;
        if (!en) begin
            dir_d = DIR_UP;
            cnt_d = '0;
        end else begin
            case (dir_q)
                DIR_UP: begin
                    if (at_peak) begin
                        dir_d = DIR_DOWN;
                    end
                end
                DIR_DOWN: begin
                    if (at_valley) begin
                        dir_d = DIR_UP;
                    end
                end
                default: dir_d = DIR_UP;
            endcase
            // The peak check wins regardless of current direction, and the
            // valley check forces up, so a stale direction can never push
            // the counter outside 0..top_act.
            if (at_peak) begin
                dir_d = DIR_DOWN;
            end else if (at_valley) begin
                dir_d = DIR_UP;
            end
            cnt_d = (dir_d == DIR_UP) ? (cnt_q + C_ONE) : (cnt_q - C_ONE);
        end
    end

    // Active TOP reload and registered sync pulses.
    always_comb begin
        top_act_d     = load_en ? top_clamped : top_act_q;
        sync_valley_d = en && at_valley;
        sync_peak_d   = en && at_peak;
    end

    // Shared counter, direction, active TOP and sync registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q         <= DIR_UP;
            cnt_q         <= '0;
            top_act_q     <= C_TOP_MAX;
            sync_valley_q <= 1'b0;
            sync_peak_q   <= 1'b0;
        end else begin
            dir_q         <= dir_d;
            cnt_q         <= cnt_d;
            top_act_q     <= top_act_d;
            sync_valley_q <= sync_valley_d;
            sync_peak_q   <= sync_peak_d;
        end
    end

    assign sync_valley = sync_valley_q;
    assign sync_peak   = sync_peak_q;

    // Per-channel duty buffering and compare. Each channel owns its shadow,
    // active compare and output flop; only the counter is shared.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [CH_W-1:0] C_IDX = CH_W'(g);

        logic [RESOLUTION:0] duty_sh_q;
        logic [RESOLUTION:0] duty_sh_d;
        logic [RESOLUTION:0] duty_act_q;
        logic [RESOLUTION:0] duty_act_d;
        logic                pwm_q;
        logic                pwm_d;

        // Shadow write, valley load (from the pre-edge shadow, so a write in
        // the valley cycle waits one more period) and the extended-width
        // compare that lets duty > TOP hold the output high.
        always_comb begin
            duty_sh_d = duty_sh_q;
            if (duty_wr_en && (duty_wr_ch == C_IDX)) begin
                duty_sh_d = duty_wr_data;
            end
            duty_act_d = load_en ? duty_sh_q : duty_act_q;
            pwm_d      = en && ({1'b0, cnt_q} < duty_act_q);
        end

        // Channel state registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                duty_sh_q  <= '0;
                duty_act_q <= '0;
                pwm_q      <= 1'b0;
            end else begin
                duty_sh_q  <= duty_sh_d;
                duty_act_q <= duty_act_d;
                pwm_q      <= pwm_d;
            end
        end

        assign pwm_out[g] = pwm_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_dual_slope_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_channel_dual_slope_pwm
//  Description : Self-checking bench for multi_channel_dual_slope_pwm.
//                A phase-based reference model predicts every output each
//                cycle; table-driven and hand-written sequences measure
//                high times and periods per window between valley pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_dual_slope_pwm;

    localparam int RES = 10;
    localparam int CHN = 4;
    localparam int CW  = 2;
    localparam int LIMIT = 5000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic [RES-1:0] top_in = 10'd1023;
    logic           duty_wr_en = 1'b0;
    logic [CW-1:0]  duty_wr_ch = '0;
    logic [RES:0]   duty_wr_data = '0;
    logic [CHN-1:0] pwm_out;
    logic           sync_valley;
    logic           sync_peak;

    int n_vec = 0;
    int n_err = 0;
    int hi [CHN];

    multi_channel_dual_slope_pwm #(
        .RESOLUTION(RES),
        .CHANNELS  (CHN),
        .CH_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .top_in      (top_in),
        .duty_wr_en  (duty_wr_en),
        .duty_wr_ch  (duty_wr_ch),
        .duty_wr_data(duty_wr_data),
        .pwm_out     (pwm_out),
        .sync_valley (sync_valley),
        .sync_peak   (sync_peak)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The period is viewed as a phase 0 .. 2*TOP-1; the counter value is a
    // triangle function of the phase.
    int             m_phase = 0;
    int             m_top = 1023;
    int             m_duty_sh [CHN];
    int             m_duty_act [CHN];
    logic [CHN-1:0] m_pwm = '0;
    logic           m_valley = 1'b0;
    logic           m_peak = 1'b0;

    function automatic int tri_cnt(input int p, input int t);
        return (p <= t) ? p : (2 * t - p);
    endfunction

    function automatic int clamp_top(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  <= 0;
            m_top    <= 1023;
            m_pwm    <= '0;
            m_valley <= 1'b0;
            m_peak   <= 1'b0;
            for (int i = 0; i < CHN; i++) begin
                m_duty_sh[i]  <= 0;
                m_duty_act[i] <= 0;
            end
        end else begin
            if (en) begin
                for (int i = 0; i < CHN; i++) begin
                    m_pwm[i] <= (tri_cnt(m_phase, m_top) < m_duty_act[i]);
                end
                m_valley <= (tri_cnt(m_phase, m_top) == 0);
                m_peak   <= (tri_cnt(m_phase, m_top) == m_top);
                if (m_phase == 0) begin
                    m_top      <= clamp_top(int'(top_in));
                    m_duty_act <= m_duty_sh;
                    m_phase    <= 1;
                end else begin
                    m_phase <= (m_phase + 1 >= 2 * m_top) ? 0 : m_phase + 1;
                end
            end else begin
                m_pwm      <= '0;
                m_valley   <= 1'b0;
                m_peak     <= 1'b0;
                m_phase    <= 0;
                m_top      <= clamp_top(int'(top_in));
                m_duty_act <= m_duty_sh;
            end
            if (duty_wr_en && (int'(duty_wr_ch) < CHN)) begin
                m_duty_sh[duty_wr_ch] <= int'(duty_wr_data);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("pwm_out", int'(pwm_out), int'(m_pwm));
            check("sync_valley", int'(sync_valley), int'(m_valley));
            check("sync_peak", int'(sync_peak), int'(m_peak));
        end
    end

    task automatic write_duty(input int ch, input int data);
        duty_wr_en   = 1'b1;
        duty_wr_ch   = CW'(ch);
        duty_wr_data = (RES + 1)'(data);
        @(negedge clk);
        duty_wr_en   = 1'b0;
    endtask

    task automatic wait_valley();
        bit seen = 1'b0;
        for (int k = 0; k < LIMIT && !seen; k++) begin
            @(negedge clk);
            seen = sync_valley;
        end
        if (!seen) check("wait_valley timeout", 0, 1);
    endtask

    // Called in a sync_valley cycle; counts high cycles per channel until the
    // next sync_valley. Optionally asserts one duty write in window cycle wr_idx.
    task automatic measure(input int wr_idx, input int wr_ch, input int wr_data,
                           output int len);
        bit done = 1'b0;
        int idx = 0;
        len = 0;
        for (int i = 0; i < CHN; i++) hi[i] = int'(pwm_out[i]);
        if (wr_idx == 0) begin
            duty_wr_en = 1'b1; duty_wr_ch = CW'(wr_ch); duty_wr_data = (RES + 1)'(wr_data);
        end
        while (!done && idx < LIMIT) begin
            @(negedge clk);
            idx++;
            duty_wr_en = 1'b0;
            if (sync_valley) begin
                done = 1'b1;
                len  = idx;
            end else begin
                for (int i = 0; i < CHN; i++) hi[i] += int'(pwm_out[i]);
                if (idx == wr_idx) begin
                    duty_wr_en = 1'b1; duty_wr_ch = CW'(wr_ch); duty_wr_data = (RES + 1)'(wr_data);
                end
            end
        end
        if (!done) check("measure timeout", 0, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int top;
        int ch;
        int duty;
        int exp_hi;
        int exp_len;
    } vec_t;

    vec_t vt [12];

    initial begin
        int len;
        vt[0]  = '{1023, 0, 512, 1023, 2046};
        vt[1]  = '{15, 1, 0, 0, 30};
        vt[2]  = '{15, 1, 16, 30, 30};
        vt[3]  = '{15, 1, 2047, 30, 30};
        vt[4]  = '{15, 2, 5, 9, 30};
        vt[5]  = '{15, 3, 10, 19, 30};
        vt[6]  = '{15, 0, 1, 1, 30};
        vt[7]  = '{15, 0, 15, 29, 30};
        vt[8]  = '{7, 1, 4, 7, 14};
        vt[9]  = '{0, 0, 1, 1, 2};
        vt[10] = '{0, 0, 2, 2, 2};
        vt[11] = '{3, 2, 3, 5, 6};

        // Reset state
        #1;
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset sync_valley", int'(sync_valley), 0);
        check("reset sync_peak", int'(sync_peak), 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // Table-driven period / high-time measurements
        foreach (vt[n]) begin
            top_in = RES'(vt[n].top);
            write_duty(vt[n].ch, vt[n].duty);
            wait_valley(); wait_valley(); wait_valley();
            measure(-1, 0, 0, len);
            check($sformatf("table[%0d] high", n), hi[vt[n].ch], vt[n].exp_hi);
            check($sformatf("table[%0d] period", n), len, vt[n].exp_len);
        end

        // Shadow timing: write mid-period vs. write in the valley cycle
        top_in = 10'd15;
        write_duty(1, 4);
        wait_valley(); wait_valley(); wait_valley();
        measure(6, 1, 12, len);
        check("shadow mid-write cur", hi[1], 7);
        measure(-1, 0, 0, len);
        check("shadow mid-write next", hi[1], 23);
        measure(6, 1, 4, len);
        check("shadow restore cur", hi[1], 23);
        measure(29, 1, 12, len);
        check("valley-write cur", hi[1], 7);
        measure(-1, 0, 0, len);
        check("valley-write next", hi[1], 7);
        measure(-1, 0, 0, len);
        check("valley-write after", hi[1], 23);

        // Independent channels
        write_duty(0, 0); write_duty(1, 5); write_duty(2, 10); write_duty(3, 16);
        wait_valley(); wait_valley(); wait_valley();
        measure(-1, 0, 0, len);
        check("chan ch0", hi[0], 0);
        check("chan ch1", hi[1], 9);
        check("chan ch2", hi[2], 19);
        check("chan ch3", hi[3], 30);
        write_duty(3, 2);
        wait_valley(); wait_valley(); wait_valley();
        measure(-1, 0, 0, len);
        check("chan3 only ch0", hi[0], 0);
        check("chan3 only ch1", hi[1], 9);
        check("chan3 only ch2", hi[2], 19);
        check("chan3 only ch3", hi[3], 2 * 2 - 1);

        // Enable drop mid down-slope, restart with new shadow duty
        write_duty(0, 10);
        wait_valley(); wait_valley(); wait_valley();
        repeat (20) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("halt pwm_out", int'(pwm_out), 0);
        check("halt sync_peak", int'(sync_peak), 0);
        write_duty(0, 3);
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("restart sync_valley", int'(sync_valley), 1);
        measure(-1, 0, 0, len);
        check("restart high", hi[0], 5);
        check("restart period", len, 30);

        // Asynchronous reset mid-count, then counting restarts from 0
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst pwm_out", int'(pwm_out), 0);
        check("async rst sync_valley", int'(sync_valley), 0);
        check("async rst sync_peak", int'(sync_peak), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst sync_valley", int'(sync_valley), 1);
        repeat (15) @(negedge clk);
        check("post-rst sync_peak", int'(sync_peak), 1);

        // Randomized traffic checked cycle by cycle against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            en         = ($urandom_range(0, 59) != 0);
            duty_wr_en = ($urandom_range(0, 3) == 0);
            duty_wr_ch = CW'($urandom_range(0, CHN - 1));
            duty_wr_data = ($urandom_range(0, 9) == 0) ? 11'd2047
                                                       : (RES + 1)'($urandom_range(0, 14));
            if ($urandom_range(0, 149) == 0) top_in = RES'($urandom_range(0, 12));
            if (k == 1500) begin
                #2 rst = 1'b1;
                #1 check("rand rst pwm_out", int'(pwm_out), 0);
                @(negedge clk);
                rst = 1'b0;
            end
        end
        duty_wr_en = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
